// File: rtl/pll_rst_pkg.sv
// Shared types and defaults for the PLL reset sequencer (pll_rst_gen).
package pll_rst_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        HOLD      = 3'd2,
        SEQ       = 3'd3,
        RUN       = 3'd4
    } pll_state_e;

    localparam int unsigned DEF_LOCK_STABLE_CYCLES = 64;
    localparam int unsigned DEF_RST_HOLD_CYCLES    = 16;
    localparam int unsigned DEF_SEQ_GAP_CYCLES     = 4;
    localparam int unsigned DEF_CNT_W              = 8;

    localparam int unsigned LLC_W = 8;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rst_sync_2ff.sv
// Generic single-bit two-flop synchronizer with asynchronous active-low clear.
module rst_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_rst_gen.sv
// Sequenced reset generator behind the system PLL: sys_rst_n first, then cpu_rst_n.
// Define LOCK_LOSS_CNT_EN to add the saturating lock_loss_cnt output.
module pll_rst_gen
    import pll_rst_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned RST_HOLD_CYCLES    = DEF_RST_HOLD_CYCLES,
    parameter int unsigned SEQ_GAP_CYCLES     = DEF_SEQ_GAP_CYCLES,
    parameter int unsigned CNT_W              = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_lock,
    input  logic             sw_rst_req,
    output logic             sys_rst_n,
    output logic             cpu_rst_n,
    output logic             rst_done
`ifdef LOCK_LOSS_CNT_EN
    ,
    output logic [LLC_W-1:0] lock_loss_cnt
`endif
);

    localparam int unsigned MAX_CYC = max3(LOCK_STABLE_CYCLES, RST_HOLD_CYCLES, SEQ_GAP_CYCLES);

    if (LOCK_STABLE_CYCLES < 1 || RST_HOLD_CYCLES < 1 || SEQ_GAP_CYCLES < 1) begin : g_cyc_check
        $error("pll_rst_gen: cycle parameters must be >= 1");
    end
    if (64'(MAX_CYC) >= (64'd1 << CNT_W)) begin : g_cnt_w_check
        $error("pll_rst_gen: CNT_W too narrow for the cycle parameters");
    end

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(SEQ_GAP_CYCLES - 1);

    logic             lock_s;
    logic             lock_drop;
    pll_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sys_rst_n_q, cpu_rst_n_q, rst_done_q;

    rst_sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pll_lock),
        .q_o   (lock_s)
    );

    assign lock_drop = (state_q != WAIT_LOCK) && !lock_s;

    // Priority: lock loss, then software request, then counter advance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
            end
            STABLE: begin
                if (cnt_q == LOCK_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (sw_rst_req) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = SEQ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SEQ: begin
                if (sw_rst_req) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (sw_rst_req) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
        if (lock_drop) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            sys_rst_n_q <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            rst_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sys_rst_n_q <= (state_d == SEQ) || (state_d == RUN);
            cpu_rst_n_q <= (state_d == RUN);
            rst_done_q  <= (state_d == RUN);
        end
    end

    assign sys_rst_n = sys_rst_n_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign rst_done  = rst_done_q;

`ifdef LOCK_LOSS_CNT_EN
    logic [LLC_W-1:0] llc_q, llc_d;

    always_comb begin
        llc_d = llc_q;
        if (lock_drop && (llc_q != '1)) begin
            llc_d = llc_q + LLC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            llc_q <= '0;
        end else begin
            llc_q <= llc_d;
        end
    end

    assign lock_loss_cnt = llc_q;
`endif

endmodule

// File: tb/tb_pll_rst_gen.sv
// Self-checking bench for pll_rst_gen: latency vectors plus lock-loss, software and board reset cases.
module tb_pll_rst_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic pll_lock;
    logic sw_rst_req;
    logic sys_rst_n;
    logic cpu_rst_n;
    logic rst_done;
`ifdef LOCK_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    int unsigned n_checks   = 0;
    int unsigned n_fail     = 0;
    int unsigned order_viol = 0;

    always #5 clk = ~clk;

    pll_rst_gen #(
        .LOCK_STABLE_CYCLES (64),
        .RST_HOLD_CYCLES    (16),
        .SEQ_GAP_CYCLES     (4),
        .CNT_W              (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pll_lock      (pll_lock),
        .sw_rst_req    (sw_rst_req),
        .sys_rst_n     (sys_rst_n),
        .cpu_rst_n     (cpu_rst_n),
        .rst_done      (rst_done)
`ifdef LOCK_LOSS_CNT_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    typedef struct {
        string name;
        int    hi1;       // edges pll_lock is high before the drop (0: no drop)
        int    lo;        // edges pll_lock is low before the final rise
        int    req_edge;  // edge index (from final rise) with sw_rst_req=1, -1 none
        int    exp_sys;
        int    exp_cpu;
        int    exp_llc;
    } vec_t;

    typedef struct {
        string name;
        int    sys_e;
        int    cpu_e;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (cpu_rst_n && !sys_rst_n) order_viol++;
    endtask

    task automatic do_reset(input logic lock);
        sw_rst_req = 1'b0;
        pll_lock   = lock;
        rst_n      = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Edge index 0 is the first edge after the call; stops at cpu_rst_n rising.
    task automatic measure(input int req_edge);
        int   sys_e = -1;
        int   cpu_e = -1;
        int   done_at_cpu = 0;
        exp_t e;
        for (int n = 0; n < 400 && cpu_e < 0; n++) begin
            sw_rst_req = (n == req_edge);
            step();
            sw_rst_req = 1'b0;
            if (sys_rst_n && sys_e < 0) sys_e = n;
            if (cpu_rst_n && cpu_e < 0) begin
                cpu_e       = n;
                done_at_cpu = int'(rst_done);
            end
        end
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check({e.name, "_sys_edge"}, sys_e, e.sys_e);
            check({e.name, "_cpu_edge"}, cpu_e, e.cpu_e);
            check({e.name, "_done"}, done_at_cpu, 1);
        end
    endtask

    task automatic check_llc(input string name, input int exp);
`ifdef LOCK_LOSS_CNT_EN
        check(name, int'(lock_loss_cnt), exp);
`else
        if (exp < 0) $display("unused %s", name);
`endif
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{"plain",          0,  0, -1, 82, 86, 0};
        vecs[1] = '{"glitch_stable", 30,  5, -1, 82, 86, 1};
        vecs[2] = '{"drop_hold",     70,  3, -1, 82, 86, 1};
        vecs[3] = '{"drop_hold_last",80,  3, -1, 82, 86, 1};
        vecs[4] = '{"short_low",     10,  1, -1, 82, 86, 1};
        vecs[5] = '{"req_wait",       0,  0,  1, 82, 86, 0};
        vecs[6] = '{"req_stable",     0,  0, 10, 82, 86, 0};
        vecs[7] = '{"req_hold",       0,  0, 70, 86, 90, 0};

        rst_n      = 1'b1;
        pll_lock   = 1'b0;
        sw_rst_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_outputs", int'({sys_rst_n, cpu_rst_n, rst_done}), 0);
        check_llc("reset_llc", 0);

        foreach (vecs[i]) begin
            int held_low = 1;
            do_reset(1'b1);
            repeat (vecs[i].hi1) begin
                step();
                if (sys_rst_n || cpu_rst_n || rst_done) held_low = 0;
            end
            if (vecs[i].hi1 > 0) begin
                pll_lock = 1'b0;
                repeat (vecs[i].lo) begin
                    step();
                    if (sys_rst_n || cpu_rst_n || rst_done) held_low = 0;
                end
                check({vecs[i].name, "_held_low"}, held_low, 1);
            end
            pll_lock = 1'b1;
            sb.push_back('{vecs[i].name, vecs[i].exp_sys, vecs[i].exp_cpu});
            measure(vecs[i].req_edge);
            check_llc({vecs[i].name, "_llc"}, vecs[i].exp_llc);
        end

        // Lock loss in RUN: outputs drop on the second edge after the low is sampled.
        do_reset(1'b1);
        repeat (90) step();
        check("a_run", int'(rst_done), 1);
        pll_lock = 1'b0;
        step();
        step();
        check("a_high_at_l1", int'({sys_rst_n, cpu_rst_n, rst_done}), 7);
        step();
        check("a_low_at_l2", int'({sys_rst_n, cpu_rst_n, rst_done}), 0);
        check_llc("a_llc", 1);
        pll_lock = 1'b1;
        sb.push_back('{"a_relock", 82, 86});
        measure(-1);

        // Software reset in RUN: back to HOLD without lock re-qualification.
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        check("b_req_edge_low", int'({sys_rst_n, cpu_rst_n, rst_done}), 0);
        sb.push_back('{"b_sw_req", 15, 19});
        measure(-1);
        check_llc("b_llc", 1);

        // Request and lock loss on the same edge: lock loss wins and is counted.
        pll_lock = 1'b0;
        step();
        step();
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        check("d_both_low", int'({sys_rst_n, cpu_rst_n, rst_done}), 0);
        check_llc("d_llc", 2);
        pll_lock = 1'b1;
        sb.push_back('{"d_relock", 82, 86});
        measure(-1);

        // Board reset in the middle of SEQ clears everything without a clock edge.
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        repeat (17) step();
        check("e_in_seq", int'({sys_rst_n, cpu_rst_n}), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("e_async_low", int'({sys_rst_n, cpu_rst_n, rst_done}), 0);
        check_llc("e_llc_cleared", 0);
        step();
        rst_n = 1'b1;
        sb.push_back('{"e_restart", 82, 86});
        measure(-1);

`ifdef LOCK_LOSS_CNT_EN
        do_reset(1'b0);
        for (int i = 0; i < 300; i++) begin
            pll_lock = 1'b1;
            repeat (3) step();
            pll_lock = 1'b0;
            repeat (3) step();
            if (i == 2) check_llc("f_llc_3", 3);
        end
        check_llc("f_llc_sat", 255);
`endif

        check("order_cpu_after_sys", int'(order_viol), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
